// File: rtl/axis_traffic_gen_pkg.sv
// Shared definitions for the AXI-Stream traffic generator: register offsets,
// control codes, read filler, FSM state type and the last-beat predicate.
package axis_traffic_gen_pkg;

    localparam logic [15:0] ADDR_CONTROL    = 16'h0010;
    localparam logic [15:0] ADDR_STATUS     = 16'h0014;
    localparam logic [15:0] ADDR_TARGET     = 16'h0018;
    localparam logic [15:0] ADDR_GAP        = 16'h001C;
    localparam logic [15:0] ADDR_SEED       = 16'h0020;
    localparam logic [15:0] ADDR_SENT_LO    = 16'h0024;
    localparam logic [15:0] ADDR_SENT_HI    = 16'h0028;
    localparam logic [15:0] ADDR_STALL_LO   = 16'h002C;
    localparam logic [15:0] ADDR_STALL_HI   = 16'h0030;
    localparam logic [15:0] ADDR_DATA_BYTES = 16'h0034;

    localparam logic [31:0] CMD_STOP  = 32'd0;
    localparam logic [31:0] CMD_START = 32'd1;
    localparam logic [31:0] CMD_CLEAR = 32'd2;

    localparam logic [31:0] RD_FILLER      = 32'h1234dead;
    localparam logic [31:0] PAT_LFSR_MASK  = 32'h80200003;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } gen_state_t;

    // True when the beat with run index 'count' is the final one of a bounded run.
    function automatic logic is_last(input logic [31:0] target, input logic [31:0] count);
        return (target != 32'd0) && ((count + 32'd1) == target);
    endfunction

endpackage

// File: rtl/axis_gen_pattern.sv
// Pattern word source for the traffic generator. Incrementing by default;
// AXIS_GEN_LFSR_EN selects a 32-bit Galois LFSR instead.
module axis_gen_pattern
    import axis_traffic_gen_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [31:0] i_seed,
    output logic [31:0] o_word
);

    logic [31:0] r_word;
    logic [31:0] w_load_val;
    logic [31:0] w_next;

`ifdef AXIS_GEN_LFSR_EN
    // An all-zero LFSR would lock up, so a zero seed starts at 1.
    assign w_load_val = (i_seed == 32'd0) ? 32'd1 : i_seed;
    assign w_next     = r_word[0] ? ((r_word >> 1) ^ PAT_LFSR_MASK) : (r_word >> 1);
`else
    assign w_load_val = i_seed;
    assign w_next     = r_word + 32'd1;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word <= 32'd0;
        end else if (i_load) begin
            r_word <= w_load_val;
        end else if (i_step) begin
            r_word <= w_next;
        end
    end

    assign o_word = r_word;

endmodule

// File: rtl/axis_traffic_gen.sv
// AXI-Stream traffic source with AXI-Lite control: programmable run length,
// inter-beat gap and seed; counts sent beats and stall cycles. See AXIS_GEN_LFSR_EN.
module axis_traffic_gen
    import axis_traffic_gen_pkg::*;
#(
    parameter int DATA_BYTES = 64,
    parameter int CTRL_BYTES = 4
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    s_axi_control_awvalid,
    output logic                    s_axi_control_awready,
    input  logic [15:0]             s_axi_control_awaddr,
    input  logic                    s_axi_control_wvalid,
    output logic                    s_axi_control_wready,
    input  logic [CTRL_BYTES*8-1:0] s_axi_control_wdata,
    input  logic [CTRL_BYTES-1:0]   s_axi_control_wstrb,
    output logic                    s_axi_control_bvalid,
    input  logic                    s_axi_control_bready,
    output logic [1:0]              s_axi_control_bresp,
    input  logic                    s_axi_control_arvalid,
    output logic                    s_axi_control_arready,
    input  logic [15:0]             s_axi_control_araddr,
    output logic                    s_axi_control_rvalid,
    input  logic                    s_axi_control_rready,
    output logic [CTRL_BYTES*8-1:0] s_axi_control_rdata,
    output logic [1:0]              s_axi_control_rresp,
    output logic [DATA_BYTES*8-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast
);

    logic                    r_bvalid;
    logic                    r_rvalid;
    logic [CTRL_BYTES*8-1:0] r_rdata;
    logic [15:0]             r_aw_addr;
    logic [31:0]             r_control;
    logic [31:0]             r_target;
    logic [31:0]             r_gap;
    logic [31:0]             r_seed;
    logic [31:0]             r_run_cnt;
    logic [31:0]             r_gap_cnt;
    logic [63:0]             r_sent;
    logic [63:0]             r_stall;
    gen_state_t              r_state;
    logic                    r_tvalid;
    logic                    r_tlast;
    logic                    r_stop_pend;
    logic                    r_clr_pend;

    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_ar_hs;
    logic        w_beat_hs;
    logic [15:0] w_wr_addr;
    logic        w_ctrl_wr;
    logic        w_cmd_start;
    logic        w_cmd_stop;
    logic        w_cmd_clear;
    logic        w_start_go;
    logic        w_busy;
    logic [31:0] w_pattern;
    logic        w_unused;

    assign s_axi_control_awready = !r_bvalid;
    assign s_axi_control_wready  = !r_bvalid;
    assign s_axi_control_bvalid  = r_bvalid;
    assign s_axi_control_bresp   = 2'b00;
    assign s_axi_control_arready = !r_rvalid;
    assign s_axi_control_rvalid  = r_rvalid;
    assign s_axi_control_rdata   = r_rdata;
    assign s_axi_control_rresp   = 2'b00;
    assign w_unused              = &{1'b0, s_axi_control_wstrb};

    assign w_aw_hs   = s_axi_control_awvalid & s_axi_control_awready;
    assign w_w_hs    = s_axi_control_wvalid & s_axi_control_wready;
    assign w_ar_hs   = s_axi_control_arvalid & s_axi_control_arready;
    assign w_beat_hs = r_tvalid & m_axis_tready;

    // A simultaneous AW takes precedence over a previously latched address.
    assign w_wr_addr   = w_aw_hs ? s_axi_control_awaddr : r_aw_addr;
    assign w_ctrl_wr   = w_w_hs && (w_wr_addr == ADDR_CONTROL);
    assign w_cmd_start = w_ctrl_wr && (s_axi_control_wdata == CMD_START);
    assign w_cmd_stop  = w_ctrl_wr && (s_axi_control_wdata == CMD_STOP);
    assign w_cmd_clear = w_ctrl_wr && (s_axi_control_wdata == CMD_CLEAR);
    assign w_start_go  = w_cmd_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_busy      = (r_state == ST_SEND) || (r_state == ST_GAP);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_bvalid  <= 1'b0;
            r_aw_addr <= 16'd0;
            r_control <= 32'd0;
            r_target  <= 32'd0;
            r_gap     <= 32'd0;
            r_seed    <= 32'd0;
        end else begin
            if (w_aw_hs && !w_w_hs) begin
                r_aw_addr <= s_axi_control_awaddr;
            end
            if (w_w_hs) begin
                r_bvalid <= 1'b1;
                case (w_wr_addr)
                    ADDR_CONTROL: r_control <= s_axi_control_wdata;
                    ADDR_TARGET:  r_target  <= s_axi_control_wdata;
                    ADDR_GAP:     r_gap     <= s_axi_control_wdata;
                    ADDR_SEED:    r_seed    <= s_axi_control_wdata;
                    default:      ;
                endcase
            end else if (s_axi_control_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            case (s_axi_control_araddr)
                ADDR_CONTROL:    r_rdata <= r_control;
                ADDR_STATUS:     r_rdata <= {30'd0, (r_state == ST_DONE), w_busy};
                ADDR_TARGET:     r_rdata <= r_target;
                ADDR_GAP:        r_rdata <= r_gap;
                ADDR_SEED:       r_rdata <= r_seed;
                ADDR_SENT_LO:    r_rdata <= r_sent[31:0];
                ADDR_SENT_HI:    r_rdata <= r_sent[63:32];
                ADDR_STALL_LO:   r_rdata <= r_stall[31:0];
                ADDR_STALL_HI:   r_rdata <= r_stall[63:32];
                ADDR_DATA_BYTES: r_rdata <= 32'(DATA_BYTES);
                default:         r_rdata <= RD_FILLER;
            endcase
        end else if (s_axi_control_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    // Run-control FSM; counter zeroing for clear is placed last so it wins.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state     <= ST_IDLE;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_stop_pend <= 1'b0;
            r_clr_pend  <= 1'b0;
            r_run_cnt   <= 32'd0;
            r_gap_cnt   <= 32'd0;
            r_sent      <= 64'd0;
            r_stall     <= 64'd0;
        end else begin
            if (r_tvalid && !m_axis_tready) begin
                r_stall <= r_stall + 64'd1;
            end
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_go) begin
                        r_state     <= ST_SEND;
                        r_tvalid    <= 1'b1;
                        r_tlast     <= is_last(r_target, 32'd0);
                        r_run_cnt   <= 32'd0;
                        r_stop_pend <= 1'b0;
                        r_clr_pend  <= 1'b0;
                    end else if (w_cmd_clear) begin
                        r_state   <= ST_IDLE;
                        r_sent    <= 64'd0;
                        r_stall   <= 64'd0;
                        r_run_cnt <= 32'd0;
                    end else if (w_cmd_stop) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (w_beat_hs) begin
                        r_sent    <= r_sent + 64'd1;
                        r_run_cnt <= r_run_cnt + 32'd1;
                        if (r_stop_pend || r_clr_pend || w_cmd_stop || w_cmd_clear) begin
                            r_state     <= ST_IDLE;
                            r_tvalid    <= 1'b0;
                            r_tlast     <= 1'b0;
                            r_stop_pend <= 1'b0;
                            r_clr_pend  <= 1'b0;
                            if (r_clr_pend || w_cmd_clear) begin
                                r_sent    <= 64'd0;
                                r_stall   <= 64'd0;
                                r_run_cnt <= 32'd0;
                            end
                        end else if (r_tlast) begin
                            r_state  <= ST_DONE;
                            r_tvalid <= 1'b0;
                            r_tlast  <= 1'b0;
                        end else if (r_gap != 32'd0) begin
                            r_state   <= ST_GAP;
                            r_gap_cnt <= r_gap;
                            r_tvalid  <= 1'b0;
                            r_tlast   <= 1'b0;
                        end else begin
                            r_tlast <= is_last(r_target, r_run_cnt + 32'd1);
                        end
                    end else begin
                        if (w_cmd_stop) begin
                            r_stop_pend <= 1'b1;
                        end
                        if (w_cmd_clear) begin
                            r_clr_pend <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (w_cmd_stop || w_cmd_clear) begin
                        r_state <= ST_IDLE;
                        if (w_cmd_clear) begin
                            r_sent    <= 64'd0;
                            r_stall   <= 64'd0;
                            r_run_cnt <= 32'd0;
                        end
                    end else if (r_gap_cnt <= 32'd1) begin
                        r_state  <= ST_SEND;
                        r_tvalid <= 1'b1;
                        r_tlast  <= is_last(r_target, r_run_cnt);
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 32'd1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_tvalid <= 1'b0;
                    r_tlast  <= 1'b0;
                end
            endcase
        end
    end

    axis_gen_pattern u_pattern (
        .i_clk   (ap_clk),
        .i_rst_n (ap_rst_n),
        .i_load  (w_start_go),
        .i_step  (w_beat_hs),
        .i_seed  (r_seed),
        .o_word  (w_pattern)
    );

    for (genvar gi = 0; gi < DATA_BYTES / 4; gi++) begin : g_lane
        assign m_axis_tdata[gi*32 +: 32] = w_pattern;
    end

    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Randomized self-checking bench for axis_traffic_gen: a beat-level reference
// model checks every handshake; register reads are checked against the model.
module tb_axis_traffic_gen;

    localparam int DB = 64;
    localparam logic [15:0] A_CONTROL  = 16'h0010;
    localparam logic [15:0] A_STATUS   = 16'h0014;
    localparam logic [15:0] A_TARGET   = 16'h0018;
    localparam logic [15:0] A_GAP      = 16'h001C;
    localparam logic [15:0] A_SEED     = 16'h0020;
    localparam logic [15:0] A_SENT_LO  = 16'h0024;
    localparam logic [15:0] A_SENT_HI  = 16'h0028;
    localparam logic [15:0] A_STALL_LO = 16'h002C;
    localparam logic [15:0] A_STALL_HI = 16'h0030;
    localparam logic [15:0] A_DBYTES   = 16'h0034;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          awvalid = 1'b0, awready;
    logic [15:0]   awaddr = '0;
    logic          wvalid = 1'b0, wready;
    logic [31:0]   wdata = '0;
    logic [3:0]    wstrb = 4'hF;
    logic          bvalid, bready = 1'b0;
    logic [1:0]    bresp;
    logic          arvalid = 1'b0, arready;
    logic [15:0]   araddr = '0;
    logic          rvalid, rready = 1'b0;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic [DB*8-1:0] tdata;
    logic          tvalid, tready = 1'b0, tlast;

    always #5 ap_clk = ~ap_clk;

    axis_traffic_gen #(.DATA_BYTES(DB), .CTRL_BYTES(4)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .s_axi_control_awvalid(awvalid), .s_axi_control_awready(awready), .s_axi_control_awaddr(awaddr),
        .s_axi_control_wvalid(wvalid), .s_axi_control_wready(wready), .s_axi_control_wdata(wdata),
        .s_axi_control_wstrb(wstrb),
        .s_axi_control_bvalid(bvalid), .s_axi_control_bready(bready), .s_axi_control_bresp(bresp),
        .s_axi_control_arvalid(arvalid), .s_axi_control_arready(arready), .s_axi_control_araddr(araddr),
        .s_axi_control_rvalid(rvalid), .s_axi_control_rready(rready), .s_axi_control_rdata(rdata),
        .s_axi_control_rresp(rresp),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tlast(tlast)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int wr_hs_cyc = 0;
    int last_hs_cyc = 0;
    int hs_count = 0;

    // Reference model of the beat stream
    logic [31:0]     m_word = '0, m_target = '0, m_gap = '0;
    int              m_idx = 0;
    bit              m_gap_chk = 0, m_lat_chk = 0;
    longint unsigned m_sent = 0, m_stall = 0;
    logic [31:0]     last_ctrl = '0, last_seed = '0;

    bit          prev_stall = 0;
    logic [31:0] prev_word = '0;
    logic        prev_last = 1'b0;

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat_load(input logic [31:0] s);
`ifdef AXIS_GEN_LFSR_EN
        return (s == 32'd0) ? 32'd1 : s;
`else
        return s;
`endif
    endfunction

    function automatic logic [31:0] pat_next(input logic [31:0] w);
`ifdef AXIS_GEN_LFSR_EN
        return w[0] ? ((w >> 1) ^ 32'h80200003) : (w >> 1);
`else
        return w + 32'd1;
`endif
    endfunction

    always @(negedge ap_clk) begin
        bit all_eq;
        if (!ap_rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check_val("stall_hold_valid", tvalid, 1);
                check_val("stall_hold_data", tdata[31:0], prev_word);
                check_val("stall_hold_last", tlast, prev_last);
            end
            if (tvalid && tready) begin
                all_eq = 1;
                for (int i = 1; i < DB / 4; i++)
                    if (tdata[i*32 +: 32] !== tdata[31:0]) all_eq = 0;
                check_val("beat_lanes", all_eq, 1);
                check_val("beat_data", tdata[31:0], m_word);
                check_val("beat_last", tlast, (m_target != 0) && (32'(m_idx + 1) == m_target));
                if (m_target != 0) check_val("beat_in_run", 32'(m_idx) < m_target, 1);
                if (m_idx == 0 && m_lat_chk) check_val("start_latency", cyc, wr_hs_cyc + 1);
                if (m_idx > 0 && m_gap_chk) check_val("beat_spacing", cyc - last_hs_cyc, m_gap + 1);
                last_hs_cyc = cyc;
                m_word = pat_next(m_word);
                m_idx++;
                m_sent++;
                hs_count++;
            end
            if (tvalid && !tready) m_stall++;
            prev_stall = tvalid && !tready;
            prev_word  = tdata[31:0];
            prev_last  = tlast;
        end
    end

    task automatic wr(input logic [15:0] addr, input logic [31:0] data);
        int n;
        @(posedge ap_clk); #1;
        awvalid = 1; wvalid = 1; awaddr = addr; wdata = data;
        n = 0;
        do begin @(negedge ap_clk); n++; end while (!(awready && wready) && n < 50);
        check_val("wr_ready", awready && wready, 1);
        wr_hs_cyc = cyc;
        @(posedge ap_clk); #1;
        awvalid = 0; wvalid = 0; bready = 1;
        n = 0;
        do begin @(negedge ap_clk); n++; end while (!bvalid && n < 50);
        check_val("wr_bvalid", bvalid, 1);
        check_val("wr_bresp", bresp, 0);
        @(posedge ap_clk); #1;
        bready = 0;
        if (addr == A_CONTROL) last_ctrl = data;
        $display("wr 0x%04h <- 0x%08h", addr, data);
    endtask

    task automatic rd(input logic [15:0] addr, output logic [31:0] data);
        int n;
        @(posedge ap_clk); #1;
        arvalid = 1; araddr = addr;
        n = 0;
        do begin @(negedge ap_clk); n++; end while (!arready && n < 50);
        check_val("rd_arready", arready, 1);
        @(posedge ap_clk); #1;
        arvalid = 0; rready = 1;
        n = 0;
        do begin @(negedge ap_clk); n++; end while (!rvalid && n < 50);
        check_val("rd_rvalid", rvalid, 1);
        check_val("rd_rresp", rresp, 0);
        data = rdata;
        @(posedge ap_clk); #1;
        rready = 0;
        $display("rd 0x%04h -> 0x%08h", addr, data);
    endtask

    task automatic rd64(input logic [15:0] lo_addr, output logic [63:0] v);
        logic [31:0] lo, hi;
        rd(lo_addr, lo);
        rd(lo_addr + 16'd4, hi);
        v = {hi, lo};
    endtask

    task automatic wait_status(input string tag, input logic [31:0] exp);
        logic [31:0] s;
        int n = 0;
        do begin rd(A_STATUS, s); n++; end while (s != exp && n < 100);
        check_val(tag, s, exp);
    endtask

    task automatic wait_hs(input int cnt, input int limit);
        int n = 0;
        while (hs_count < cnt && n < limit) begin @(negedge ap_clk); n++; end
        check_val("wait_hs", hs_count >= cnt, 1);
    endtask

    task automatic start_run(input logic [31:0] tgt, input logic [31:0] gap,
                             input logic [31:0] seed, input bit spacing, input bit lat);
        wr(A_TARGET, tgt);
        wr(A_GAP, gap);
        wr(A_SEED, seed);
        last_seed = seed;
        m_word = pat_load(seed); m_idx = 0; m_target = tgt; m_gap = gap;
        m_gap_chk = spacing; m_lat_chk = lat;
        wr(A_CONTROL, 32'd1);
    endtask

    initial begin
        logic [31:0] v;
        logic [63:0] v64;
        int hsb, tgt, n;

        // Reset state
        repeat (3) @(negedge ap_clk);
        check_val("rst_tvalid", tvalid, 0);
        check_val("rst_tlast", tlast, 0);
        check_val("rst_tdata", |tdata, 0);
        check_val("rst_awready", awready, 1);
        check_val("rst_wready", wready, 1);
        check_val("rst_arready", arready, 1);
        check_val("rst_bvalid", bvalid, 0);
        check_val("rst_rvalid", rvalid, 0);
        @(posedge ap_clk); #1;
        ap_rst_n = 1;
        rd(A_STATUS, v);   check_val("rst_status", v, 0);
        rd(A_DBYTES, v);   check_val("data_bytes_reg", v, DB);

        // Bounded back-to-back run: 7,8,9,10 with tlast on the last
        tready = 1;
        start_run(32'd4, 32'd0, 32'd7, 1, 1);
        wait_status("A_status_done", 32'd2);
        check_val("A_beats", m_idx, 4);
        rd64(A_SENT_LO, v64); check_val("A_sent", v64, 64'd4);

        // Gap timing: handshakes 4 cycles apart
        tgt = $urandom_range(4, 7);
        start_run(tgt, 32'd3, $urandom, 1, 1);
        wait_status("B_status_done", 32'd2);
        check_val("B_beats", m_idx, tgt);

        // Backpressure for 5 cycles mid-run
        start_run(32'd12, 32'd0, $urandom, 0, 1);
        wait_hs(hs_count + 3, 100);
        @(posedge ap_clk); #1; tready = 0;
        repeat (5) @(posedge ap_clk);
        #1; tready = 1;
        rd(A_STATUS, v); check_val("C_status_busy", v, 32'd1);
        wait_status("C_status_done", 32'd2);
        check_val("C_beats", m_idx, 12);
        rd64(A_STALL_LO, v64); check_val("C_stall", v64, 64'd5);
        rd64(A_SENT_LO, v64);  check_val("C_sent", v64, m_sent);

        // Stop written while the current beat is stalled
        start_run(32'd0, 32'd0, $urandom, 0, 1);
        wait_hs(hs_count + 2, 100);
        @(posedge ap_clk); #1; tready = 0;
        repeat (2) @(posedge ap_clk);
        hsb = hs_count;
        wr(A_CONTROL, 32'd0);
        @(negedge ap_clk);
        check_val("D_hold_valid", tvalid, 1);
        check_val("D_no_beat_yet", hs_count - hsb, 0);
        @(posedge ap_clk); #1; tready = 1;
        repeat (6) @(negedge ap_clk);
        check_val("D_one_more_beat", hs_count - hsb, 1);
        check_val("D_valid_low", tvalid, 0);
        rd(A_STATUS, v); check_val("D_status_idle", v, 32'd0);

        // Clear, then unbounded run under random backpressure
        wr(A_CONTROL, 32'd2);
        m_sent = 0; m_stall = 0;
        rd64(A_SENT_LO, v64);  check_val("E_sent_clr", v64, 64'd0);
        rd64(A_STALL_LO, v64); check_val("E_stall_clr", v64, 64'd0);
        start_run(32'd0, $urandom_range(0, 2), $urandom, 0, 0);
        for (int i = 0; i < 60; i++) begin
            @(posedge ap_clk); #1; tready = 1'($urandom_range(0, 1));
        end
        wr(A_CONTROL, 32'd0);
        @(posedge ap_clk); #1; tready = 1;
        wait_status("E_status_idle", 32'd0);
        rd64(A_SENT_LO, v64);  check_val("E_sent", v64, m_sent);
        rd64(A_STALL_LO, v64); check_val("E_stall", v64, m_stall);

        // Random bounded runs, including a single-beat run and a wrapping seed
        for (int r = 0; r < 4; r++) begin
            tgt = (r == 0) ? 1 : $urandom_range(2, 6);
            start_run(tgt, $urandom_range(0, 3), (r == 1) ? 32'hFFFFFFFE : $urandom, 0, 0);
            n = 0;
            while (m_idx < tgt && n < 400) begin
                @(posedge ap_clk); #1; tready = 1'($urandom_range(0, 1)); n++;
            end
            @(posedge ap_clk); #1; tready = 1;
            wait_status("R_status_done", 32'd2);
            check_val("R_beats", m_idx, tgt);
        end
        rd64(A_SENT_LO, v64);  check_val("R_sent", v64, m_sent);
        rd64(A_STALL_LO, v64); check_val("R_stall", v64, m_stall);

        // AW two cycles ahead of W lands at the latched address
        @(posedge ap_clk); #1;
        awvalid = 1; awaddr = A_GAP;
        @(negedge ap_clk);
        check_val("aw_only_ready", awready, 1);
        @(posedge ap_clk); #1;
        awvalid = 0; awaddr = A_SEED;
        @(posedge ap_clk); #1;
        wvalid = 1; wdata = 32'd5;
        @(negedge ap_clk);
        check_val("w_only_ready", wready, 1);
        @(posedge ap_clk); #1;
        wvalid = 0; bready = 1;
        n = 0;
        do begin @(negedge ap_clk); n++; end while (!bvalid && n < 50);
        check_val("w_only_bvalid", bvalid, 1);
        @(posedge ap_clk); #1; bready = 0;
        $display("wr 0x%04h <- 0x%08h (address phase 2 cycles early)", A_GAP, 32'd5);
        rd(A_GAP, v);  check_val("latched_addr_gap", v, 32'd5);
        rd(A_SEED, v); check_val("latched_addr_seed", v, last_seed);
        rd(16'h0040, v); check_val("unmapped_read", v, 32'h1234dead);
        rd(A_CONTROL, v); check_val("control_readback", v, last_ctrl);
        wr(A_STATUS, 32'hFF);
        rd(A_STATUS, v); check_val("ro_write_dropped", v, 32'd2);

        // Reset asserted during a stalled beat
        tready = 0;
        start_run(32'd0, 32'd0, $urandom, 0, 0);
        n = 0;
        while (!tvalid && n < 20) begin @(negedge ap_clk); n++; end
        check_val("F_valid_before_rst", tvalid, 1);
        @(posedge ap_clk); #1;
        ap_rst_n = 0;
        #1;
        check_val("F_rst_valid", tvalid, 0);
        check_val("F_rst_last", tlast, 0);
        check_val("F_rst_data", |tdata, 0);
        @(posedge ap_clk); #1;
        ap_rst_n = 1;
        rd(A_STATUS, v);      check_val("F_status", v, 32'd0);
        rd64(A_SENT_LO, v64); check_val("F_sent", v64, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 0x0, expected 0x1");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "timeout");
    end

endmodule
